// File: rtl/wb_stage_if.sv
// Handshake and writeback bus between the MEM stage and the writeback stage.
// Master drives instructions and memory responses. Slave returns the register-file write port.
interface wb_stage_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        wb_sel;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [2:0]              ld_funct3;
  logic [1:0]              addr_lo;
  logic [4:0]              rd;
  logic                    reg_we;
  logic                    flush;
  logic                    mem_rvalid;
  logic [XLEN-1:0]         mem_rdata;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    ld_err;
  logic                    busy;

  modport master (
    output in_valid, wb_sel, src_data, ld_funct3, addr_lo, rd, reg_we, flush,
           mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, ld_err, busy
  );

  modport slave (
    input  in_valid, wb_sel, src_data, ld_funct3, addr_lo, rd, reg_we, flush,
           mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, ld_err, busy
  );
endinterface

// File: rtl/wb_stage.sv
// Registered writeback stage: selects a result source, or waits (with a timeout) for load data and formats it.
// Latency is 1 cycle after accept or after the load data arrives. in_ready is low while a load waits in WAIT.
module wb_stage #(
  parameter int XLEN        = 32,
  parameter int NUM_SRC     = 5,
  parameter int SEL_W       = 3,
  parameter int MEM_SEL     = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]      lat_rd;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [1:0]      lat_lo;
  logic [XLEN-1:0] src_sel;
  logic            accept;
  logic            is_load;

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [XLEN-1:0] d);
    logic [XLEN-1:0] bsh;
    logic [XLEN-1:0] hsh;
    logic [7:0]      b;
    logic [15:0]     h;
    bsh = d >> {lo, 3'b000};
    hsh = d >> {lo[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (f3)
      F3_LB:   fmt_load = {{(XLEN-8){b[7]}}, b};
      F3_LH:   fmt_load = {{(XLEN-16){h[15]}}, h};
      F3_LW:   fmt_load = d;
      F3_LBU:  fmt_load = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = '0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    misaligned = ((f3 == F3_LH || f3 == F3_LHU) && lo[0]) ||
                 ((f3 == F3_LW) && (lo != 2'b00));
  endfunction

  // Out-of-range selects fall through to zero.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.wb_sel == SEL_W'(i)) src_sel = bus.src_data[i*XLEN +: XLEN];
    end
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state == S_WAIT);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign is_load      = (bus.wb_sel == SEL_W'(MEM_SEL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lat_rd       <= '0;
      lat_we       <= 1'b0;
      lat_f3       <= '0;
      lat_lo       <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.ld_err   <= 1'b0;
    end else begin
      bus.rf_we  <= 1'b0;
      bus.ld_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_load) begin
              bus.rf_wdata <= src_sel;
              bus.rf_waddr <= bus.rd;
              bus.rf_we    <= bus.reg_we & (bus.rd != 5'd0);
            end else if (misaligned(bus.ld_funct3, bus.addr_lo)) begin
              bus.ld_err <= 1'b1;
            end else if (bus.mem_rvalid) begin
              bus.rf_wdata <= fmt_load(bus.ld_funct3, bus.addr_lo, bus.mem_rdata);
              bus.rf_waddr <= bus.rd;
              bus.rf_we    <= bus.reg_we & (bus.rd != 5'd0);
            end else begin
              lat_rd <= bus.rd;
              lat_we <= bus.reg_we;
              lat_f3 <= bus.ld_funct3;
              lat_lo <= bus.addr_lo;
              cnt    <= '0;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A flush wins over data arriving in the same cycle.
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (bus.mem_rvalid) begin
            bus.rf_wdata <= fmt_load(lat_f3, lat_lo, bus.mem_rdata);
            bus.rf_waddr <= lat_rd;
            bus.rf_we    <= lat_we & (lat_rd != 5'd0);
            state        <= S_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            bus.ld_err <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a table of single-cycle vectors, then hand-written multi-cycle sequences.
// Every register-file write or error pulse is popped from a scoreboard and compared.
module tb_wb_stage;
  localparam int XLEN = 32, NUM_SRC = 5, SEL_W = 3, TO = 16;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus();

  wb_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .MEM_SEL(1), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rwe;
    logic        rv;
    logic        ewe;
    logic [31:0] ed;
    logic        eerr;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.rf_we || bus.ld_err) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: rf_we=%0b ld_err=%0b waddr=%0d, want no event",
                 bus.rf_we, bus.ld_err, bus.rf_waddr);
      end else begin
        e = sb.pop_front();
        chk("sb_we", {31'd0, bus.rf_we}, {31'd0, e.we});
        chk("sb_err", {31'd0, bus.ld_err}, {31'd0, e.err});
        if (e.we) begin
          chk("sb_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.waddr});
          chk("sb_wdata", bus.rf_wdata, e.wdata);
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [4:0] rd, input logic rwe,
                       input logic rv, input logic [31:0] rdata, input logic fl);
    bus.in_valid   = v;
    bus.wb_sel     = sel;
    bus.ld_funct3  = f3;
    bus.addr_lo    = lo;
    bus.rd         = rd;
    bus.reg_we     = rwe;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
    bus.flush      = fl;
  endtask

  function automatic vec_t mkv(input logic [2:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                               input logic [4:0] rd, input logic rwe, input logic rv,
                               input logic ewe, input logic [31:0] ed, input logic eerr);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.lo = lo; v.rd = rd; v.rwe = rwe; v.rv = rv;
    v.ewe = ewe; v.ed = ed; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = mkv(3'd0, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
    vecs[1]  = mkv(3'd2, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'h00000044, 1'b0);
    vecs[2]  = mkv(3'd3, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'h12345000, 1'b0);
    vecs[3]  = mkv(3'd4, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'h00001000, 1'b0);
    vecs[4]  = mkv(3'd7, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0);
    vecs[5]  = mkv(3'd5, LB,  2'd0, 5'd5,  1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0);
    vecs[6]  = mkv(3'd1, LB,  2'd3, 5'd9,  1'b1, 1'b1, 1'b1, 32'hFFFFFF88, 1'b0);
    vecs[7]  = mkv(3'd1, LBU, 2'd0, 5'd10, 1'b1, 1'b1, 1'b1, 32'h000000BB, 1'b0);
    vecs[8]  = mkv(3'd1, LH,  2'd2, 5'd11, 1'b1, 1'b1, 1'b1, 32'hFFFF8899, 1'b0);
    vecs[9]  = mkv(3'd1, LHU, 2'd0, 5'd12, 1'b1, 1'b1, 1'b1, 32'h0000AABB, 1'b0);
    vecs[10] = mkv(3'd1, LW,  2'd0, 5'd13, 1'b1, 1'b1, 1'b1, 32'h8899AABB, 1'b0);
    vecs[11] = mkv(3'd1, LB,  2'd1, 5'd14, 1'b1, 1'b1, 1'b1, 32'hFFFFFFAA, 1'b0);
    vecs[12] = mkv(3'd1, LHU, 2'd2, 5'd15, 1'b1, 1'b1, 1'b1, 32'h00008899, 1'b0);
    vecs[13] = mkv(3'd1, LBU, 2'd2, 5'd16, 1'b1, 1'b1, 1'b1, 32'h00000099, 1'b0);
    vecs[14] = mkv(3'd1, 3'b011, 2'd0, 5'd17, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b0);
    vecs[15] = mkv(3'd1, LW,  2'd2, 5'd18, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    vecs[16] = mkv(3'd1, LH,  2'd1, 5'd19, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    vecs[17] = mkv(3'd1, LHU, 2'd3, 5'd20, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    vecs[18] = mkv(3'd0, LB,  2'd0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[19] = mkv(3'd0, LB,  2'd0, 5'd7,  1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[20] = mkv(3'd2, LB,  2'd0, 5'd31, 1'b1, 1'b1, 1'b1, 32'h00000044, 1'b0);

    rst = 1'b1;
    bus.src_data = {32'h00001000, 32'h12345000, 32'h00000044, 32'hDEADBEEF, 32'hAAAAAAAA};
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_ld_err", {31'd0, bus.ld_err}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // in_valid stays high across the whole table, so every vector is a back-to-back accept.
    for (int i = 0; i < 21; i++) begin
      chk("vec_in_ready", {31'd0, bus.in_ready}, 32'd1);
      drive(1'b1, vecs[i].sel, vecs[i].f3, vecs[i].lo, vecs[i].rd, vecs[i].rwe,
            vecs[i].rv, 32'h8899AABB, 1'b0);
      if (vecs[i].ewe || vecs[i].eerr)
        sb.push_back('{we: vecs[i].ewe, waddr: vecs[i].rd, wdata: vecs[i].ed, err: vecs[i].eerr});
      tick();
      chk("vec_latency", sb.size(), 32'd0);
    end
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // Delayed load with a second instruction held on in_valid.
    drive(1'b1, 3'd1, LW, 2'd0, 5'd12, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 3'd0, LB, 2'd3, 5'd6, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("dly_busy", {31'd0, bus.busy}, 32'd1);
      chk("dly_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    chk("dly_busy_rv", {31'd0, bus.busy}, 32'd1);
    sb.push_back('{we: 1'b1, waddr: 5'd12, wdata: 32'hCAFEF00D, err: 1'b0});
    tick();
    chk("dly_write_lat", sb.size(), 32'd0);
    chk("dly_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.mem_rvalid = 1'b0;
    sb.push_back('{we: 1'b1, waddr: 5'd6, wdata: 32'hAAAAAAAA, err: 1'b0});
    tick();
    chk("dly_second_lat", sb.size(), 32'd0);
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Timeout: no data ever arrives.
    drive(1'b1, 3'd1, LW, 2'd0, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    sb.push_back('{we: 1'b0, waddr: 5'd0, wdata: 32'h0, err: 1'b1});
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, TO);
    chk("to_err_seen", sb.size(), 32'd0);
    chk("to_idle", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("to_err_pulse", {31'd0, bus.ld_err}, 32'd0);

    // Flush in WAIT beats a simultaneous mem_rvalid.
    drive(1'b1, 3'd1, LW, 2'd0, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("fl_busy_before", {31'd0, bus.busy}, 32'd1);
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b1, 32'h12345678, 1'b1);
    tick();
    chk("fl_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("fl_no_write", {31'd0, bus.rf_we}, 32'd0);
    chk("fl_no_err", {31'd0, bus.ld_err}, 32'd0);

    // Flush in IDLE blocks the accept.
    drive(1'b1, 3'd0, LB, 2'd0, 5'd8, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    chk("fl_idle_no_write", {31'd0, bus.rf_we}, 32'd0);
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("fl_idle_no_late", {31'd0, bus.rf_we}, 32'd0);

    // Reset mid-WAIT clears outputs without waiting for a clock edge.
    drive(1'b1, 3'd3, LB, 2'd0, 5'd9, 1'b1, 1'b0, 32'h0, 1'b0);
    sb.push_back('{we: 1'b1, waddr: 5'd9, wdata: 32'h12345000, err: 1'b0});
    tick();
    drive(1'b1, 3'd1, LW, 2'd0, 5'd10, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("rw_busy", {31'd0, bus.busy}, 32'd1);
    chk("rw_wdata_held", bus.rf_wdata, 32'h12345000);
    rst = 1'b1;
    #1;
    chk("rw_busy_async", {31'd0, bus.busy}, 32'd0);
    chk("rw_rf_we_async", {31'd0, bus.rf_we}, 32'd0);
    chk("rw_wdata_async", bus.rf_wdata, 32'd0);
    chk("rw_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b0, 3'd0, LB, 2'd0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("rw_still_idle", {31'd0, bus.busy}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Registered, handshaked writeback stage for the pipelined RV32I core, succeeding the combinational writeback mux.
- Accepts one retiring instruction per cycle from the MEM stage.
- Selects among NUM_SRC packed result sources.
- Waits for late load data with a timeout.
- Aligns and sign- or zero-extends load data.
- Drives the register-file write port one cycle later, and flags misaligned loads and load timeouts.

Parameters:
XLEN, 32, datapath width in bits.
NUM_SRC, 5, number of packed sources: 0=ALU, 1=MEM, 2=PC+4, 3=U-imm, 4=PC+imm.
SEL_W, 3, width of wb_sel.
MEM_SEL, 1, wb_sel value meaning "load data from memory response".
TIMEOUT_CYC, 16, maximum cycles spent in WAIT before abort; must be ≥1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  MEM stage presents an instruction.
in_ready  output  1  stage can accept this cycle.
wb_sel  input  SEL_W  source select.
src_data  input  NUM_SRC*XLEN  packed sources; source i occupies bits [i*XLEN +: XLEN]; slot MEM_SEL is ignored.
ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
addr_lo  input  2  load byte offset.
rd  input  5  destination register.
reg_we  input  1  instruction writes rd.
flush  input  1  abandon any pending load.
mem_rvalid  input  1  memory read data valid.
mem_rdata  input  XLEN  memory read word.
rf_we  output  1  register-file write enable, registered.
rf_waddr  output  5  register-file write address, registered.
rf_wdata  output  XLEN  register-file write data, registered.
ld_err  output  1  one-cycle pulse on misaligned load or timeout.
busy  output  1  high while in WAIT.

Behaviour:
- States: IDLE, WAIT. Reset: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, ld_err=0, timeout counter=0.
- in_ready = (state==IDLE). busy = (state==WAIT). Accept = in_valid & in_ready.
- **Non-load accept** (wb_sel≠MEM_SEL):
  - Next edge: rf_wdata = src[wb_sel] if wb_sel<NUM_SRC, else 0.
  - rf_waddr = rd; rf_we = reg_we & (rd≠0). Latency 1. Back-to-back accepts every cycle.
- **Load accept** (wb_sel==MEM_SEL), misaligned case: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
  - No wait; next edge rf_we=0, ld_err=1.
- **Load accept, aligned, mem_rvalid=1 in the same cycle:** completes like a non-load (latency 1) using the formatted mem_rdata.
- **Load accept, aligned, mem_rvalid=0:** latch rd, reg_we, funct3, addr_lo; go to WAIT; counter=0.
- **WAIT:**
  - Each cycle: if mem_rvalid → write the formatted data next edge, go to IDLE.
  - Else the counter increments. When counter reaches TIMEOUT_CYC-1 without data → ld_err=1, rf_we=0, go to IDLE.
- **Load formatting:**
  - byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16].
  - LB and LH sign-extend to XLEN; LBU and LHU zero-extend; LW passes the word.
  - Any other funct3 → data 0, written normally.
- **Pulses:** rf_we and ld_err are single-cycle; both are 0 in any cycle without a completion or error.
- **flush:**
  - In WAIT: go to IDLE next edge with no write and no ld_err. flush has priority over a simultaneous mem_rvalid.
  - In IDLE: blocks accept that cycle (in_valid ignored).
- mem_rvalid while IDLE with no load accept is ignored.
- rst mid-WAIT: immediate return to IDLE; outputs cleared asynchronously.
- Invalid wb_sel (≥NUM_SRC, ≠MEM_SEL) writes 0, preserving the legacy "safe 0" behaviour.

Test Plan:
1. **All sources.** ALU=AAAAAAAA, PC+4=00000044, U=12345000, PC+imm=00001000, rd=5, reg_we=1. For wb_sel=0,2,3,4,7 → rf_wdata=AAAAAAAA, 00000044, 12345000, 00001000, 00000000 respectively, each one cycle after accept, rf_we=1, rf_waddr=5. in_valid held high 5 cycles → 5 consecutive writes.
2. **Load formatting.** mem_rdata=8899AABB returned same cycle:
   - LB addr_lo=3 → FFFFFF88.
   - LBU addr_lo=0 → 000000BB.
   - LH addr_lo=2 → FFFF8899.
   - LHU addr_lo=0 → 0000AABB.
   - LW → 8899AABB.
3. **Delayed load.** Load accepted, mem_rvalid after 3 cycles:
   - in_ready=0 and busy=1 for 3 cycles.
   - Write on the cycle after mem_rvalid.
   - A second instruction held on in_valid is accepted only after return to IDLE.
4. **Misaligned and timeout.**
   - LW addr_lo=2 → ld_err pulse, rf_we=0.
   - Aligned load with no mem_rvalid → ld_err after TIMEOUT_CYC cycles in WAIT, return to IDLE, no write.
5. **rd=0 and reg_we=0.** rd=0 with reg_we=1, and rd=7 with reg_we=0 → rf_we stays 0 for both.
6. **flush and reset.**
   - flush in WAIT together with mem_rvalid → no write, no ld_err, IDLE next cycle.
   - rst asserted mid-WAIT → immediately busy=0, rf_we=0, rf_wdata=0.
